// File: rtl/sdram_responder.sv
// Device-side SDR SDRAM model: decodes zs_* commands, tracks init and bank
// state, stores data in a small array and returns reads after CAS latency.
module sdram_responder #(
  parameter int ROW_W        = 3,
  parameter int COL_W        = 5,
  parameter int TRCD         = 2,
  parameter int INIT_REFRESH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        zs_cke,
  input  logic        zs_cs_n,
  input  logic        zs_ras_n,
  input  logic        zs_cas_n,
  input  logic        zs_we_n,
  input  logic [1:0]  zs_ba,
  input  logic [11:0] zs_addr,
  input  logic [1:0]  zs_dqm,
  input  logic [15:0] dq_in,
  output logic [15:0] dq_out,
  output logic        dq_oe,
  output logic        init_done,
  output logic        err,
  output logic [2:0]  err_code
);
  localparam int AW = 2 + ROW_W + COL_W;
  localparam int TW = (TRCD > 1) ? $clog2(TRCD) : 1;
  localparam int RW = (INIT_REFRESH > 1) ? $clog2(INIT_REFRESH) : 1;

  localparam logic [1:0] ST_UNINIT = 2'd0;
  localparam logic [1:0] ST_PRE    = 2'd1;
  localparam logic [1:0] ST_REF    = 2'd2;
  localparam logic [1:0] ST_READY  = 2'd3;

  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_RD  = 3'b101;
  localparam logic [2:0] CMD_WR  = 3'b100;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam logic [2:0] CMD_LMR = 3'b000;
  localparam logic [2:0] CMD_NOP = 3'b111;

  logic [1:0]       state_q, state_d;
  logic [RW-1:0]    ref_q, ref_d;
  logic             cl3_q, cl3_d;
  logic [3:0]       open_q, open_d;
  logic [ROW_W-1:0] row_q [4];
  logic [ROW_W-1:0] row_d [4];
  logic [TW-1:0]    trcd_q [4];
  logic [TW-1:0]    trcd_d [4];
  logic             err_q;
  logic [2:0]       code_q;
  logic [2:0]       ecode;
  logic             mem_we, rd_v, ready, mode_ok;
  logic [2:0]       cmd;
  logic [AW-1:0]    idx;
  logic [15:0]      mem [0:(2**AW)-1];
  logic [15:0]      rd_raw, rd_word;
  logic [2:0]       pv_q;
  logic [15:0]      pd_q [3];
  logic [15:0]      dq_out_q;
  logic             dq_oe_q;
  logic             unused_addr;

  assign unused_addr = ^zs_addr;
  assign cmd     = (zs_cke && !zs_cs_n) ? {zs_ras_n, zs_cas_n, zs_we_n} : CMD_NOP;
  assign ready   = (state_q == ST_READY);
  assign mode_ok = ((zs_addr[6:4] == 3'd2) || (zs_addr[6:4] == 3'd3)) && (zs_addr[2:0] == 3'b000);
  assign idx     = {zs_ba, row_q[zs_ba], zs_addr[COL_W-1:0]};
  assign rd_raw  = mem[idx];
  assign rd_word = {zs_dqm[1] ? 8'h00 : rd_raw[15:8], zs_dqm[0] ? 8'h00 : rd_raw[7:0]};

  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    cl3_d   = cl3_q;
    open_d  = open_q;
    row_d   = row_q;
    for (int unsigned b = 0; b < 4; b++)
      trcd_d[b] = (trcd_q[b] != '0) ? trcd_q[b] - TW'(1) : trcd_q[b];
    ecode  = 3'd0;
    mem_we = 1'b0;
    rd_v   = 1'b0;
    case (cmd)
      CMD_ACT: begin
        if (!ready) ecode = 3'd1;
        else begin
          if (open_q[zs_ba]) ecode = 3'd3;
          open_d[zs_ba] = 1'b1;
          row_d[zs_ba]  = zs_addr[ROW_W-1:0];
          trcd_d[zs_ba] = TW'(TRCD - 1);
        end
      end
      CMD_RD, CMD_WR: begin
        if (!ready) ecode = 3'd1;
        else if (!open_q[zs_ba]) ecode = 3'd2;
        else begin
          // A too-early access is flagged but still carried out.
          if (trcd_q[zs_ba] != '0) ecode = 3'd4;
          if (cmd == CMD_WR) mem_we = 1'b1;
          else rd_v = 1'b1;
        end
      end
      CMD_PRE: begin
        if (zs_addr[10]) open_d = '0;
        else open_d[zs_ba] = 1'b0;
        if (state_q == ST_UNINIT && zs_addr[10]) state_d = ST_PRE;
      end
      CMD_REF: begin
        if (ready && open_q != '0) ecode = 3'd5;
        else if (state_q == ST_PRE) begin
          if (ref_q == RW'(INIT_REFRESH - 1)) begin
            state_d = ST_REF;
            ref_d   = '0;
          end else ref_d = ref_q + RW'(1);
        end
      end
      CMD_LMR: begin
        if (state_q == ST_UNINIT || state_q == ST_PRE) ecode = 3'd1;
        else if (!mode_ok) ecode = 3'd6;
        else if (state_q == ST_REF || open_q == '0) begin
          cl3_d   = zs_addr[4];
          state_d = ST_READY;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_UNINIT;
      ref_q    <= '0;
      cl3_q    <= 1'b0;
      open_q   <= '0;
      err_q    <= 1'b0;
      code_q   <= 3'd0;
      pv_q     <= '0;
      dq_out_q <= '0;
      dq_oe_q  <= 1'b0;
      for (int unsigned b = 0; b < 4; b++) begin
        row_q[b]  <= '0;
        trcd_q[b] <= '0;
      end
      for (int unsigned s = 0; s < 3; s++) pd_q[s] <= '0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      cl3_q   <= cl3_d;
      open_q  <= open_d;
      row_q   <= row_d;
      trcd_q  <= trcd_d;
      if (!err_q && ecode != 3'd0) begin
        err_q  <= 1'b1;
        code_q <= ecode;
      end
      // Stage n holds the read issued n+1 edges ago; the output register adds one.
      pv_q    <= {pv_q[1:0], rd_v};
      pd_q[0] <= rd_word;
      pd_q[1] <= pd_q[0];
      pd_q[2] <= pd_q[1];
      dq_oe_q  <= cl3_q ? pv_q[2] : pv_q[1];
      dq_out_q <= cl3_q ? (pv_q[2] ? pd_q[2] : '0) : (pv_q[1] ? pd_q[1] : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      if (!zs_dqm[0]) mem[idx][7:0]  <= dq_in[7:0];
      if (!zs_dqm[1]) mem[idx][15:8] <= dq_in[15:8];
    end
  end

  assign dq_out    = dq_out_q;
  assign dq_oe     = dq_oe_q;
  assign init_done = (state_q == ST_READY);
  assign err       = err_q;
  assign err_code  = code_q;
endmodule

// File: tb/tb_sdram_responder.sv
// Bench for sdram_responder: scenario tasks plus randomized traffic, all
// checked against a cycle-numbered behavioural model of the SDRAM rules.
module tb_sdram_responder;
  localparam int ROW_W = 3, COL_W = 5, TRCD = 2, INIT_REFRESH = 2;
  localparam int K_NOP = 0, K_ACT = 1, K_RD = 2, K_WR = 3, K_PRE = 4, K_REF = 5,
                 K_LMR = 6, K_BST = 7, K_DESEL = 8, K_CKE0 = 9;

  typedef struct {
    int          k;
    logic [1:0]  ba;
    logic [11:0] addr;
    logic [1:0]  dqm;
    logic [15:0] din;
  } cmd_t;

  logic        clk = 1'b0, rst = 1'b1;
  logic        zs_cke = 1'b1, zs_cs_n = 1'b1, zs_ras_n = 1'b1, zs_cas_n = 1'b1, zs_we_n = 1'b1;
  logic [1:0]  zs_ba = '0, zs_dqm = '0;
  logic [11:0] zs_addr = '0;
  logic [15:0] dq_in = '0, dq_out;
  logic        dq_oe, init_done, err;
  logic [2:0]  err_code;

  sdram_responder #(.ROW_W(ROW_W), .COL_W(COL_W), .TRCD(TRCD), .INIT_REFRESH(INIT_REFRESH)) dut (
    .clk(clk), .rst(rst), .zs_cke(zs_cke), .zs_cs_n(zs_cs_n), .zs_ras_n(zs_ras_n),
    .zs_cas_n(zs_cas_n), .zs_we_n(zs_we_n), .zs_ba(zs_ba), .zs_addr(zs_addr),
    .zs_dqm(zs_dqm), .dq_in(dq_in), .dq_out(dq_out), .dq_oe(dq_oe),
    .init_done(init_done), .err(err), .err_code(err_code));

  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0;

  // Model state: init stage 0..3 (3 = ready), banks, per-address memory,
  // and expected read returns keyed by the edge number they appear at.
  int          m_stage, m_refs, m_cl;
  bit          m_err;
  logic [2:0]  m_code;
  bit          m_open [4];
  int          m_row [4];
  int          m_act [4];
  logic [15:0] m_mem [int];
  logic [15:0] exp_dq [int];
  logic        e_oe;
  logic [15:0] e_dq;

  function automatic cmd_t mk(input int k, input logic [1:0] ba = 2'd0, input logic [11:0] addr = 12'd0,
                              input logic [1:0] dqm = 2'd0, input logic [15:0] din = 16'd0);
    cmd_t c;
    c.k = k; c.ba = ba; c.addr = addr; c.dqm = dqm; c.din = din;
    return c;
  endfunction

  task automatic do_reset(input int n);
    rst = 1'b1; zs_cke = 1'b1; zs_cs_n = 1'b1;
    {zs_ras_n, zs_cas_n, zs_we_n} = 3'b111;
    repeat (n) begin @(posedge clk); cyc++; end
    @(negedge clk);
    m_stage = 0; m_refs = 0; m_cl = 2; m_err = 1'b0; m_code = 3'd0;
    for (int b = 0; b < 4; b++) begin m_open[b] = 1'b0; m_act[b] = -1000; end
    exp_dq.delete();
    e_oe = 1'b0; e_dq = '0;
    rst = 1'b0;
  endtask

  task automatic step(input cmd_t c);
    int e, edge_n, idx, ml;
    bit any_open;
    logic [15:0] w;
    rst = 1'b0; zs_cke = 1'b1; zs_cs_n = 1'b0;
    zs_ba = c.ba; zs_addr = c.addr; zs_dqm = c.dqm; dq_in = c.din;
    case (c.k)
      K_ACT:   {zs_ras_n, zs_cas_n, zs_we_n} = 3'b011;
      K_RD:    {zs_ras_n, zs_cas_n, zs_we_n} = 3'b101;
      K_WR:    {zs_ras_n, zs_cas_n, zs_we_n} = 3'b100;
      K_PRE:   {zs_ras_n, zs_cas_n, zs_we_n} = 3'b010;
      K_REF:   {zs_ras_n, zs_cas_n, zs_we_n} = 3'b001;
      K_LMR:   {zs_ras_n, zs_cas_n, zs_we_n} = 3'b000;
      K_BST:   {zs_ras_n, zs_cas_n, zs_we_n} = 3'b110;
      K_DESEL: begin zs_cs_n = 1'b1; {zs_ras_n, zs_cas_n, zs_we_n} = 3'b101; end
      K_CKE0:  begin zs_cke = 1'b0;  {zs_ras_n, zs_cas_n, zs_we_n} = 3'b101; end
      default: {zs_ras_n, zs_cas_n, zs_we_n} = 3'b111;
    endcase
    edge_n = cyc + 1;
    e = 0;
    any_open = m_open[0] | m_open[1] | m_open[2] | m_open[3];
    idx = (int'(c.ba) << (ROW_W + COL_W)) | (m_row[c.ba] << COL_W) | (int'(c.addr) & ((1 << COL_W) - 1));
    ml = int'(c.addr[6:4]);
    case (c.k)
      K_ACT: if (m_stage != 3) e = 1;
             else begin
               if (m_open[c.ba]) e = 3;
               m_open[c.ba] = 1'b1;
               m_row[c.ba] = int'(c.addr) & ((1 << ROW_W) - 1);
               m_act[c.ba] = edge_n;
             end
      K_RD, K_WR: if (m_stage != 3) e = 1;
             else if (!m_open[c.ba]) e = 2;
             else begin
               if (edge_n - m_act[c.ba] < TRCD) e = 4;
               w = m_mem.exists(idx) ? m_mem[idx] : 16'hxxxx;
               if (c.k == K_WR) begin
                 if (!c.dqm[0]) w[7:0] = c.din[7:0];
                 if (!c.dqm[1]) w[15:8] = c.din[15:8];
                 m_mem[idx] = w;
               end else begin
                 if (c.dqm[0]) w[7:0] = 8'h00;
                 if (c.dqm[1]) w[15:8] = 8'h00;
                 exp_dq[edge_n + m_cl] = w;
               end
             end
      K_PRE: begin
               if (c.addr[10]) for (int b = 0; b < 4; b++) m_open[b] = 1'b0;
               else m_open[c.ba] = 1'b0;
               if (m_stage == 0 && c.addr[10]) m_stage = 1;
             end
      K_REF: if (m_stage == 3 && any_open) e = 5;
             else if (m_stage == 1) begin
               m_refs++;
               if (m_refs == INIT_REFRESH) m_stage = 2;
             end
      K_LMR: if (m_stage < 2) e = 1;
             else if (!((ml == 2 || ml == 3) && c.addr[2:0] == 3'b000)) e = 6;
             else if (m_stage == 2 || !any_open) begin m_cl = ml; m_stage = 3; end
      default: ;
    endcase
    if (e != 0 && !m_err) begin m_err = 1'b1; m_code = 3'(e); end
    @(posedge clk); cyc++;
    @(negedge clk);
    e_oe = exp_dq.exists(cyc);
    e_dq = e_oe ? exp_dq[cyc] : 16'h0;
    if (e_oe) exp_dq.delete(cyc);
  endtask

  task automatic do_init(input logic [11:0] mode);
    step(mk(K_PRE, 2'd0, 12'h400));
    repeat (INIT_REFRESH) step(mk(K_REF));
    step(mk(K_LMR, 2'd0, mode));
  endtask

  task automatic test_reset;
    do_reset(2);
    checks++;
    if (dq_oe !== 1'b0 || dq_out !== 16'h0) begin
      errors++; $display("FAIL reset_dq: oe=%b dq=%h expected oe=0 dq=0000", dq_oe, dq_out);
    end
    checks++;
    if (init_done !== 1'b0 || err !== 1'b0 || err_code !== 3'd0) begin
      errors++; $display("FAIL reset_status: init=%b err=%b code=%0d expected 0 0 0", init_done, err, err_code);
    end
  endtask

  task automatic test_init;
    cmd_t q[$];
    q = '{mk(K_PRE, 2'd0, 12'h400), mk(K_REF), mk(K_REF), mk(K_LMR, 2'd0, 12'h020)};
    foreach (q[i]) begin
      step(q[i]);
      checks++;
      if (init_done !== (m_stage == 3) || err !== m_err) begin
        errors++; $display("FAIL init[%0d]: init=%b err=%b expected init=%0d err=%0d", i, init_done, err, m_stage == 3, m_err);
      end
    end
    checks++;
    if (init_done !== 1'b1 || err !== 1'b0 || err_code !== 3'd0) begin
      errors++; $display("FAIL init_final: init=%b err=%b code=%0d expected 1 0 0", init_done, err, err_code);
    end
  endtask

  task automatic test_write_read;
    cmd_t q[$];
    int at_i[4] = '{6, 11, 22, 23};
    logic at_oe[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [15:0] at_dq[4] = '{16'hBEEF, 16'hBE34, 16'h0000, 16'hBE34};
    q = '{mk(K_ACT, 2'd1, 12'd5), mk(K_NOP), mk(K_NOP), mk(K_WR, 2'd1, 12'd3, 2'b00, 16'hBEEF),
          mk(K_RD, 2'd1, 12'd3), mk(K_NOP), mk(K_NOP), mk(K_NOP),
          mk(K_WR, 2'd1, 12'd3, 2'b10, 16'h1234), mk(K_RD, 2'd1, 12'd3), mk(K_NOP), mk(K_NOP), mk(K_NOP),
          mk(K_PRE, 2'd0, 12'h400), mk(K_NOP), mk(K_LMR, 2'd0, 12'h030), mk(K_NOP),
          mk(K_ACT, 2'd1, 12'd5), mk(K_NOP), mk(K_NOP), mk(K_RD, 2'd1, 12'd3),
          mk(K_NOP), mk(K_NOP), mk(K_NOP), mk(K_NOP)};
    foreach (q[i]) begin
      step(q[i]);
      checks++;
      if (dq_oe !== e_oe || (e_oe && dq_out !== e_dq) || err !== m_err) begin
        errors++; $display("FAIL wr_rd[%0d]: oe=%b dq=%h err=%b expected oe=%b dq=%h err=%0d", i, dq_oe, dq_out, err, e_oe, e_dq, m_err);
      end
      for (int j = 0; j < 4; j++)
        if (at_i[j] == i) begin
          checks++;
          if (dq_oe !== at_oe[j] || (at_oe[j] && dq_out !== at_dq[j])) begin
            errors++; $display("FAIL wr_rd_latency[%0d]: oe=%b dq=%h expected oe=%b dq=%h", i, dq_oe, dq_out, at_oe[j], at_dq[j]);
          end
        end
    end
  endtask

  task automatic test_back_to_back;
    cmd_t q[$];
    int oe_run = 0, oe_max = 0;
    for (int c = 8; c < 12; c++) q.push_back(mk(K_WR, 2'd1, 12'(c), 2'b00, 16'($urandom)));
    for (int c = 8; c < 12; c++) q.push_back(mk(K_RD, 2'd1, 12'(c), 2'($urandom_range(0, 3))));
    q.push_back(mk(K_WR, 2'd1, 12'd12, 2'b00, 16'($urandom)));
    q.push_back(mk(K_RD, 2'd1, 12'd12));
    repeat (5) q.push_back(mk(K_NOP));
    foreach (q[i]) begin
      step(q[i]);
      oe_run = dq_oe ? oe_run + 1 : 0;
      if (oe_run > oe_max) oe_max = oe_run;
      checks++;
      if (dq_oe !== e_oe || (e_oe && dq_out !== e_dq)) begin
        errors++; $display("FAIL b2b[%0d]: oe=%b dq=%h expected oe=%b dq=%h", i, dq_oe, dq_out, e_oe, e_dq);
      end
    end
    checks++;
    if (oe_max != 4) begin
      errors++; $display("FAIL b2b_run: longest dq_oe run=%0d expected 4", oe_max);
    end
  endtask

  task automatic test_random;
    cmd_t c;
    int r;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      c = mk(K_NOP, 2'($urandom_range(0, 3)), 12'(($urandom & 32'hFE0) | $urandom_range(0, 3)),
             2'($urandom_range(0, 3)), 16'($urandom));
      if (r < 15)      begin c.k = K_ACT; c.addr = 12'(($urandom & 32'hFF8) | $urandom_range(0, 1)); end
      else if (r < 40) c.k = K_RD;
      else if (r < 65) c.k = K_WR;
      else if (r < 73) begin c.k = K_PRE; c.addr[10] = ($urandom_range(0, 3) == 0); end
      else if (r < 76) c.k = K_REF;
      else if (r < 80) c.k = K_BST;
      else if (r < 84) c.k = K_DESEL;
      else if (r < 88) c.k = K_CKE0;
      step(c);
      checks++;
      if (dq_oe !== e_oe || (e_oe && !$isunknown(e_dq) && dq_out !== e_dq)) begin
        errors++; $display("FAIL rand_data[%0d]: oe=%b dq=%h expected oe=%b dq=%h", i, dq_oe, dq_out, e_oe, e_dq);
      end
      checks++;
      if (err !== m_err || err_code !== m_code || init_done !== (m_stage == 3)) begin
        errors++; $display("FAIL rand_status[%0d]: err=%b code=%0d init=%b expected err=%0d code=%0d init=%0d",
                           i, err, err_code, init_done, m_err, m_code, m_stage == 3);
      end
    end
  endtask

  task automatic test_err_init;
    cmd_t q[$];
    do_reset(1);
    q = '{mk(K_RD, 2'd0, 12'd3), mk(K_NOP), mk(K_NOP), mk(K_ACT, 2'd1, 12'd5),
          mk(K_PRE, 2'd0, 12'h400), mk(K_LMR, 2'd0, 12'h020), mk(K_REF), mk(K_REF),
          mk(K_LMR, 2'd0, 12'h023), mk(K_NOP)};
    foreach (q[i]) begin
      step(q[i]);
      checks++;
      if (dq_oe !== e_oe || err !== m_err || err_code !== m_code || init_done !== (m_stage == 3)) begin
        errors++; $display("FAIL err_init[%0d]: oe=%b err=%b code=%0d init=%b expected oe=%b err=%0d code=%0d init=%0d",
                           i, dq_oe, err, err_code, init_done, e_oe, m_err, m_code, m_stage == 3);
      end
    end
    checks++;
    if (err !== 1'b1 || err_code !== 3'd1 || init_done !== 1'b0) begin
      errors++; $display("FAIL err_init_final: err=%b code=%0d init=%b expected 1 1 0", err, err_code, init_done);
    end
  endtask

  task automatic test_err_closed;
    cmd_t q[$];
    int oe_seen = 0;
    do_reset(1);
    do_init(12'h020);
    q = '{mk(K_ACT, 2'd1, 12'd5), mk(K_NOP), mk(K_NOP), mk(K_PRE, 2'd1, 12'h000),
          mk(K_RD, 2'd1, 12'd3), mk(K_NOP), mk(K_NOP), mk(K_NOP)};
    foreach (q[i]) begin
      step(q[i]);
      if (dq_oe === 1'b1) oe_seen++;
      checks++;
      if (dq_oe !== e_oe || err !== m_err || err_code !== m_code) begin
        errors++; $display("FAIL err_closed[%0d]: oe=%b err=%b code=%0d expected oe=%b err=%0d code=%0d",
                           i, dq_oe, err, err_code, e_oe, m_err, m_code);
      end
    end
    checks++;
    if (err_code !== 3'd2 || oe_seen != 0) begin
      errors++; $display("FAIL err_closed_final: code=%0d oe_cycles=%0d expected code=2 oe_cycles=0", err_code, oe_seen);
    end
  endtask

  task automatic test_err_trcd;
    cmd_t q[$];
    logic [15:0] got = '0;
    int oe_seen = 0;
    do_reset(1);
    do_init(12'h020);
    q = '{mk(K_ACT, 2'd1, 12'd5), mk(K_RD, 2'd1, 12'd3), mk(K_NOP), mk(K_NOP), mk(K_NOP)};
    foreach (q[i]) begin
      step(q[i]);
      if (dq_oe === 1'b1) begin oe_seen++; got = dq_out; end
      checks++;
      if (dq_oe !== e_oe || (e_oe && dq_out !== e_dq) || err_code !== m_code) begin
        errors++; $display("FAIL err_trcd[%0d]: oe=%b dq=%h code=%0d expected oe=%b dq=%h code=%0d",
                           i, dq_oe, dq_out, err_code, e_oe, e_dq, m_code);
      end
    end
    checks++;
    if (err_code !== 3'd4 || oe_seen != 1 || got !== 16'hBE34) begin
      errors++; $display("FAIL err_trcd_final: code=%0d oe_cycles=%0d dq=%h expected code=4 oe_cycles=1 dq=be34", err_code, oe_seen, got);
    end
  endtask

  task automatic test_err_refresh;
    do_reset(1);
    do_init(12'h020);
    step(mk(K_ACT, 2'd0, 12'd1));
    step(mk(K_REF));
    checks++;
    if (err !== m_err || err_code !== m_code || err_code !== 3'd5) begin
      errors++; $display("FAIL err_refresh: err=%b code=%0d expected err=%0d code=%0d (5)", err, err_code, m_err, m_code);
    end
  endtask

  task automatic test_err_mode;
    do_reset(1);
    do_init(12'h023);
    checks++;
    if (err_code !== 3'd6 || init_done !== 1'b0 || init_done !== (m_stage == 3)) begin
      errors++; $display("FAIL err_mode: code=%0d init=%b expected code=6 init=0", err_code, init_done);
    end
    step(mk(K_LMR, 2'd0, 12'h020));
    checks++;
    if (init_done !== 1'b1 || err_code !== 3'd6) begin
      errors++; $display("FAIL err_mode_recover: init=%b code=%0d expected init=1 code=6", init_done, err_code);
    end
  endtask

  task automatic test_reset_midread;
    do_reset(1);
    do_init(12'h020);
    step(mk(K_ACT, 2'd1, 12'd5));
    step(mk(K_NOP));
    step(mk(K_NOP));
    step(mk(K_RD, 2'd1, 12'd3));
    step(mk(K_NOP));
    do_reset(1);
    checks++;
    if (dq_oe !== 1'b0 || init_done !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL midread_reset: oe=%b init=%b err=%b expected 0 0 0", dq_oe, init_done, err);
    end
    step(mk(K_NOP));
    checks++;
    if (dq_oe !== 1'b0 || dq_oe !== e_oe) begin
      errors++; $display("FAIL midread_after: oe=%b expected 0", dq_oe);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_write_read();
    test_back_to_back();
    test_random();
    test_err_init();
    test_err_closed();
    test_err_trcd();
    test_err_refresh();
    test_err_mode();
    test_reset_midread();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
